// File: rtl/ni_flit_injector_pkg.sv
// ni_flit_injector_pkg: flit-id constants, address field widths and header field layout
package ni_flit_injector_pkg;
  localparam logic [2:0] HEADER = 3'b001;
  localparam logic [2:0] BODY   = 3'b010;
  localparam logic [2:0] TAIL   = 3'b100;
  localparam int X_W     = 2;
  localparam int Y_W     = 2;
  localparam int ADDR_W  = X_W + Y_W;
  localparam int LEN_W   = 4;
  localparam int DST_OFF = 0;
  localparam int SRC_OFF = 4;
  localparam int LEN_OFF = 8;
  localparam int HDR_W   = LEN_OFF + LEN_W;
  function automatic logic [HDR_W-1:0] header_word(input logic [LEN_W-1:0] len,
                                                   input logic [ADDR_W-1:0] src,
                                                   input logic [ADDR_W-1:0] dst);
    header_word = '0;
    header_word[LEN_OFF +: LEN_W]  = len;
    header_word[SRC_OFF +: ADDR_W] = src;
    header_word[DST_OFF +: ADDR_W] = dst;
  endfunction
endpackage

// File: rtl/ni_flit_injector_credit_counter.sv
// credit_counter: saturating credit counter mirroring free slots in the router local FIFO
//   clk, rst   : clock, async active-high reset (counter returns to DEPTH)
//   inc        : credit returned by the router
//   dec        : flit issued this cycle (only asserted while has_credit)
//   has_credit : at least one free slot
//   credit_err : sticky, credit returned while counter already full
module credit_counter #(
  parameter int DEPTH = 4,
  parameter int W     = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic has_credit,
  output logic credit_err
);
  localparam logic [W-1:0] FULL = W'(DEPTH);
  logic [W-1:0] credit;
  assign has_credit = credit != '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit     <= FULL;
      credit_err <= 1'b0;
    end else if (inc && !dec) begin
      if (credit == FULL) credit_err <= 1'b1;
      else credit <= credit + 1'b1;
    end else if (dec && !inc) begin
      credit <= credit - 1'b1;
    end
  end
endmodule

// File: rtl/ni_flit_injector.sv
// ni_flit_injector: frames core packet requests into HEADER/BODY/TAIL flits under credit flow control
//   src_addr                  : this node's {y,x}
//   pkt_valid/ready/dst/len   : packet request handshake
//   data_valid/ready/data_in  : payload word handshake
//   flit_valid/id/data/dst    : registered flit stream into the router local FIFO
//   credit_in/credit_err      : credit return pulse, sticky over-return flag
//   pkt_sent                  : TAIL flits issued, wrapping
module ni_flit_injector
  import ni_flit_injector_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        src_addr,
  input  logic              pkt_valid,
  output logic              pkt_ready,
  input  logic [3:0]        pkt_dst,
  input  logic [3:0]        pkt_len,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              flit_valid,
  output logic [2:0]        flit_id,
  output logic [DATA_W-1:0] flit_data,
  output logic [3:0]        flit_dst,
  input  logic              credit_in,
  output logic              credit_err,
  output logic [CNT_W-1:0]  pkt_sent
);
  typedef enum logic [1:0] {IDLE, HEAD, PAYLOAD} state_t;
  state_t     state;
  logic [3:0] rem;
  logic       has_credit;
  logic       issue;
  logic       last;
  // rem==0 in PAYLOAD only happens for a zero-length packet: its TAIL needs no data word
  always_comb begin
    data_ready = state == PAYLOAD && rem != '0 && has_credit;
    issue      = has_credit && (state == HEAD || (state == PAYLOAD && (rem == '0 || data_valid)));
    last       = rem <= 4'd1;
  end
  credit_counter #(.DEPTH(FIFO_DEPTH)) u_credit (
    .clk       (clk),
    .rst       (rst),
    .inc       (credit_in),
    .dec       (issue),
    .has_credit(has_credit),
    .credit_err(credit_err)
  );
  // flit_dst doubles as the latched destination so it is stable from HEADER through TAIL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pkt_ready  <= 1'b0;
      flit_valid <= 1'b0;
      flit_id    <= '0;
      flit_data  <= '0;
      flit_dst   <= '0;
      rem        <= '0;
      pkt_sent   <= '0;
    end else begin
      flit_valid <= issue;
      case (state)
        IDLE: begin
          if (pkt_ready && pkt_valid) begin
            flit_dst  <= pkt_dst;
            rem       <= pkt_len;
            pkt_ready <= 1'b0;
            state     <= HEAD;
          end else begin
            pkt_ready <= 1'b1;
          end
        end
        HEAD: begin
          if (issue) begin
            flit_id   <= HEADER;
            flit_data <= DATA_W'(header_word(rem, src_addr, flit_dst));
            state     <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (issue) begin
            flit_id   <= last ? TAIL : BODY;
            flit_data <= rem == '0 ? '0 : data_in;
            rem       <= rem - 1'b1;
            if (last) begin
              state     <= IDLE;
              pkt_ready <= 1'b1;
              pkt_sent  <= pkt_sent + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
